// File: rtl/scc_pkg.sv
// rtl/scc_pkg.sv - shared SCC serial types: FSM states and FIFO entry layout
package scc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } scc_state_t;

   typedef struct packed {
      logic       brk;
      logic       perr;
      logic       ferr;
      logic [7:0] data;
   } scc_entry_t;

   localparam int FIFO_DEPTH = 4;

endpackage

// File: rtl/scc_rx_fifo.sv
// rtl/scc_rx_fifo.sv - 4-entry receive FIFO with registered head and sticky overrun
module scc_rx_fifo
   import scc_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_push,
   input  logic [10:0] i_din,
   input  logic        i_pop,
   output logic [10:0] o_head,
   output logic        o_valid,
   output logic        o_overrun
);

   logic [10:0] r_mem [FIFO_DEPTH];
   logic [1:0]  r_rd;
   logic [1:0]  r_wr;
   logic [2:0]  r_cnt;
   logic [10:0] r_head;
   logic        r_overrun;

   logic        w_full;
   logic        w_pop;
   logic        w_wr;
   logic [1:0]  w_rd_next;
   logic [2:0]  w_cnt_next;

   assign w_full     = (r_cnt == 3'(FIFO_DEPTH));
   assign w_pop      = i_pop && (r_cnt != 3'd0);
   assign w_wr       = i_push && (!w_full || w_pop);
   assign w_rd_next  = w_pop ? r_rd + 2'd1 : r_rd;
   assign w_cnt_next = r_cnt + {2'b00, w_wr} - {2'b00, w_pop};

   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[r_wr] <= i_din;
   end

   // Head is loaded one step ahead; a push landing in the new head slot bypasses memory.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd      <= 2'd0;
         r_wr      <= 2'd0;
         r_cnt     <= 3'd0;
         r_head    <= 11'd0;
         r_overrun <= 1'b0;
      end else begin
         r_rd  <= w_rd_next;
         r_cnt <= w_cnt_next;
         if (w_wr)
            r_wr <= r_wr + 2'd1;
         if (w_cnt_next != 3'd0)
            r_head <= (w_wr && (r_wr == w_rd_next)) ? i_din : r_mem[w_rd_next];
         if (w_pop)
            r_overrun <= 1'b0;
         else if (i_push && w_full)
            r_overrun <= 1'b1;
      end
   end

   assign o_head    = r_head;
   assign o_valid   = (r_cnt != 3'd0);
   assign o_overrun = r_overrun;

endmodule

// File: rtl/scc_async_rx.sv
// rtl/scc_async_rx.sv - 16x oversampled async serial receiver feeding a 4-entry FIFO
module scc_async_rx
   import scc_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   input  logic       rd_strobe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       framing_err,
   output logic       parity_err,
   output logic       break_det,
   output logic       overrun
);

   localparam int            TW    = $clog2(CLK_DIV);
   localparam logic [TW-1:0] TLOAD = TW'(CLK_DIV - 1);
   localparam logic          P_EN  = (PARITY_EN != 0);
   localparam logic          P_ODD = (PARITY_ODD != 0);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_rxd_d;
   logic [TW-1:0] r_tcnt;
   logic [3:0]    r_sc;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_perr;
   scc_state_t    r_state;

   logic          w_rxd;
   logic          w_tick;
   logic          w_fall;
   logic          w_start;
   logic          w_centre;
   logic          w_push;
   logic          w_ferr;
   logic [10:0]   w_entry;
   scc_entry_t    w_head;

   assign w_rxd    = r_sync2;
   assign w_tick   = (r_tcnt == '0);
   assign w_fall   = r_rxd_d & ~w_rxd;
   assign w_start  = (r_state == IDLE) & w_fall;
   assign w_centre = w_tick & (r_sc == 4'd15);
   assign w_push   = (r_state == STOP) & w_centre;
   assign w_ferr   = ~w_rxd;
   assign w_entry  = {w_ferr & (r_shift == 8'h00), r_perr, w_ferr, r_shift};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_rxd_d <= 1'b1;
      end else begin
         r_sync1 <= rxd;
         r_sync2 <= r_sync1;
         r_rxd_d <= r_sync2;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_tcnt <= TLOAD;
      else if (w_start || w_tick)
         r_tcnt <= TLOAD;
      else
         r_tcnt <= r_tcnt - TW'(1);
   end

   // Start is armed on a falling edge, so a held-low break yields a single entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_sc    <= 4'd0;
         r_bit   <= 3'd0;
         r_shift <= 8'h00;
         r_perr  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_fall) begin
                  r_state <= START;
                  r_sc    <= 4'd0;
                  r_perr  <= 1'b0;
               end
            end
            START: begin
               if (w_tick) begin
                  if (r_sc == 4'd7) begin
                     r_sc    <= 4'd0;
                     r_bit   <= 3'd0;
                     r_state <= w_rxd ? IDLE : DATA;
                  end else begin
                     r_sc <= r_sc + 4'd1;
                  end
               end
            end
            DATA: begin
               if (w_tick) begin
                  r_sc <= r_sc + 4'd1;
                  if (r_sc == 4'd15) begin
                     r_shift <= {w_rxd, r_shift[7:1]};
                     r_bit   <= r_bit + 3'd1;
                     if (r_bit == 3'd7)
                        r_state <= P_EN ? PARITY : STOP;
                  end
               end
            end
            PARITY: begin
               if (w_tick) begin
                  r_sc <= r_sc + 4'd1;
                  if (r_sc == 4'd15) begin
                     r_perr  <= ((^r_shift) ^ w_rxd) != P_ODD;
                     r_state <= STOP;
                  end
               end
            end
            STOP: begin
               if (w_tick) begin
                  r_sc <= r_sc + 4'd1;
                  if (r_sc == 4'd15)
                     r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   scc_rx_fifo u_fifo (
      .clk       (clk),
      .reset     (reset),
      .i_push    (w_push),
      .i_din     (w_entry),
      .i_pop     (rd_strobe),
      .o_head    (w_head),
      .o_valid   (rx_valid),
      .o_overrun (overrun)
   );

   assign rx_data     = w_head.data;
   assign framing_err = w_head.ferr;
   assign parity_err  = w_head.perr;
   assign break_det   = w_head.brk;

endmodule

// File: tb/tb_scc_async_rx.sv
// tb/tb_scc_async_rx.sv - directed bench for scc_async_rx, 8N1 and 8E1 instances
module tb_scc_async_rx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rxd_a = 1'b1;
   logic       rxd_p = 1'b1;
   logic       rd_a = 1'b0;
   logic       rd_p = 1'b0;

   logic [7:0] data_a, data_p;
   logic       valid_a, valid_p;
   logic       ferr_a, ferr_p;
   logic       perr_a, perr_p;
   logic       brk_a, brk_p;
   logic       ovr_a, ovr_p;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   scc_async_rx #(.CLK_DIV(4), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .rxd         (rxd_a),
      .rd_strobe   (rd_a),
      .rx_data     (data_a),
      .rx_valid    (valid_a),
      .framing_err (ferr_a),
      .parity_err  (perr_a),
      .break_det   (brk_a),
      .overrun     (ovr_a)
   );

   scc_async_rx #(.CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_p (
      .clk         (clk),
      .reset       (reset),
      .rxd         (rxd_p),
      .rd_strobe   (rd_p),
      .rx_data     (data_p),
      .rx_valid    (valid_p),
      .framing_err (ferr_p),
      .parity_err  (perr_p),
      .break_det   (brk_p),
      .overrun     (ovr_p)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // sel 0 drives the 8N1 line, sel 1 the 8E1 line; nmax truncates the frame
   task automatic send_frame(input int sel, input logic [7:0] d, input logic pbit,
                             input logic stop, input int nmax);
      logic [10:0] v;
      int          n;
      if (sel == 0) begin
         v = {1'b1, stop, d, 1'b0};
         n = 10;
      end else begin
         v = {stop, pbit, d, 1'b0};
         n = 11;
      end
      if (nmax < n)
         n = nmax;
      for (int i = 0; i < n; i++) begin
         if (sel == 0) rxd_a = v[i];
         else          rxd_p = v[i];
         repeat (64) @(posedge clk);
      end
      if (sel == 0) rxd_a = 1'b1;
      else          rxd_p = 1'b1;
   endtask

   task automatic wait_valid(input int sel, input string tag);
      logic v;
      v = 1'b0;
      for (int i = 0; i < 1000 && !v; i++) begin
         @(negedge clk);
         v = (sel == 0) ? valid_a : valid_p;
      end
      check(tag, {31'd0, v}, 32'd1);
   endtask

   task automatic pop(input int sel);
      @(negedge clk);
      if (sel == 0) rd_a = 1'b1;
      else          rd_p = 1'b1;
      @(negedge clk);
      rd_a = 1'b0;
      rd_p = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_data", {24'd0, data_a}, 32'h00);
      check("rst_valid", {31'd0, valid_a}, 32'd0);
      check("rst_flags", {28'd0, ferr_a, perr_a, brk_a, ovr_a}, 32'd0);
      check("rst_valid_p", {31'd0, valid_p}, 32'd0);
      reset = 1'b0;
      repeat (10) @(posedge clk);

      // 8N1 0x55
      send_frame(0, 8'h55, 1'b0, 1'b1, 10);
      wait_valid(0, "v55_valid");
      check("v55_data", {24'd0, data_a}, 32'h55);
      check("v55_flags", {28'd0, ferr_a, perr_a, brk_a, ovr_a}, 32'd0);
      pop(0);
      check("v55_empty", {31'd0, valid_a}, 32'd0);

      // short low glitch then 0xC3
      rxd_a = 1'b0;
      repeat (20) @(posedge clk);
      rxd_a = 1'b1;
      repeat (100) @(posedge clk);
      @(negedge clk);
      check("glitch_nopush", {31'd0, valid_a}, 32'd0);
      send_frame(0, 8'hC3, 1'b0, 1'b1, 10);
      wait_valid(0, "vc3_valid");
      check("vc3_data", {24'd0, data_a}, 32'hC3);
      check("vc3_flags", {28'd0, ferr_a, perr_a, brk_a, ovr_a}, 32'd0);
      pop(0);

      // 0xA3 with stop bit low
      send_frame(0, 8'hA3, 1'b0, 1'b0, 10);
      repeat (50) @(posedge clk);
      wait_valid(0, "va3_valid");
      check("va3_data", {24'd0, data_a}, 32'hA3);
      check("va3_ferr_brk", {30'd0, ferr_a, brk_a}, 32'b10);
      pop(0);

      // break: line low for 12 bit times
      rxd_a = 1'b0;
      repeat (12 * 64) @(posedge clk);
      rxd_a = 1'b1;
      repeat (200) @(posedge clk);
      wait_valid(0, "brk_valid");
      check("brk_data", {24'd0, data_a}, 32'h00);
      check("brk_ferr_brk", {30'd0, ferr_a, brk_a}, 32'b11);
      pop(0);
      check("brk_single", {31'd0, valid_a}, 32'd0);

      // even parity, 0x31 has three ones
      send_frame(1, 8'h31, 1'b0, 1'b1, 11);
      wait_valid(1, "par0_valid");
      check("par0_data", {24'd0, data_p}, 32'h31);
      check("par0_perr", {30'd0, perr_p, ferr_p}, 32'b10);
      pop(1);
      send_frame(1, 8'h31, 1'b1, 1'b1, 11);
      wait_valid(1, "par1_valid");
      check("par1_perr", {30'd0, perr_p, ferr_p}, 32'b00);
      pop(1);
      check("par_empty", {31'd0, valid_p}, 32'd0);

      // five frames back to back, no reads
      for (int k = 1; k <= 5; k++)
         send_frame(0, 8'(k), 1'b0, 1'b1, 10);
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("ovr_valid", {31'd0, valid_a}, 32'd1);
      check("ovr_head", {24'd0, data_a}, 32'h01);
      check("ovr_set", {31'd0, ovr_a}, 32'd1);
      pop(0);
      check("ovr_clr", {31'd0, ovr_a}, 32'd0);
      check("ovr_head2", {24'd0, data_a}, 32'h02);
      pop(0);
      check("ovr_head3", {24'd0, data_a}, 32'h03);
      pop(0);
      check("ovr_head4", {24'd0, data_a}, 32'h04);
      pop(0);
      check("ovr_drained", {31'd0, valid_a}, 32'd0);

      // reset mid-frame with an entry queued
      send_frame(0, 8'h5A, 1'b0, 1'b1, 10);
      wait_valid(0, "v5a_valid");
      send_frame(0, 8'h77, 1'b0, 1'b1, 4);
      rxd_a = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      rxd_a = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_rst_data", {24'd0, data_a}, 32'h00);
      check("mid_rst_out", {27'd0, valid_a, ferr_a, perr_a, brk_a, ovr_a}, 32'd0);
      reset = 1'b0;
      repeat (100) @(posedge clk);
      @(negedge clk);
      check("mid_rst_idle", {31'd0, valid_a}, 32'd0);
      send_frame(0, 8'h96, 1'b0, 1'b1, 10);
      wait_valid(0, "v96_valid");
      check("v96_data", {24'd0, data_a}, 32'h96);
      check("v96_flags", {28'd0, ferr_a, perr_a, brk_a, ovr_a}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
